// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : hazard_scoreboard
// Description : RAW-hazard scoreboard for a pipelined RV32I core. Tracks up
//               to DEPTH in-flight register writers between issue and
//               writeback, stalls the issue slot while a source operand is
//               not yet obtainable, and counts stall cycles (saturating).
//               Optional feature macro: HAZARD_FORWARD_EN -- when defined,
//               per-operand forwarding selects are driven and only loads
//               that have not yet reached the last stage cause a stall.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_scoreboard #(
  parameter int REG_ADDR_W = 5,
  parameter int DEPTH      = 3,
  parameter int FWD_W      = $clog2(DEPTH + 1)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  issue_valid,
  input  logic [REG_ADDR_W-1:0] issue_rd,
  input  logic                  issue_regwrite,
  input  logic                  issue_load,
  input  logic [REG_ADDR_W-1:0] issue_rs1,
  input  logic [REG_ADDR_W-1:0] issue_rs2,
  input  logic                  issue_use_rs1,
  input  logic                  issue_use_rs2,
  input  logic                  flush,
  output logic                  stall,
  output logic [FWD_W-1:0]      fwd_sel1,
  output logic [FWD_W-1:0]      fwd_sel2,
  output logic [15:0]           stall_count
);

  localparam logic [15:0] C_COUNT_MAX = 16'hFFFF;

  // In-flight writer pipe; index 0 is the youngest entry
  logic [DEPTH-1:0]      r_valid;
  logic [DEPTH-1:0]      r_load;
  logic [REG_ADDR_W-1:0] r_rd [DEPTH];
  logic [15:0]           r_stall_count;

  // Youngest-match results per source operand
  logic w_hit1;
  logic w_hit2;
  logic w_ld1;
  logic w_ld2;
  int   w_idx1;
  int   w_idx2;

  logic w_haz1;
  logic w_haz2;
  logic w_stall;
  logic w_accept;

  // Find the youngest valid entry writing each used, nonzero source register
  always_comb begin
    w_hit1 = 1'b0;
    w_hit2 = 1'b0;
    w_ld1  = 1'b0;
    w_ld2  = 1'b0;
    w_idx1 = 0;
    w_idx2 = 0;
    // Walk oldest to youngest so the youngest match is the one left standing
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (issue_use_rs1 && (issue_rs1 != '0) && r_valid[i] && (r_rd[i] == issue_rs1)) begin
        w_hit1 = 1'b1;
        w_ld1  = r_load[i];
        w_idx1 = i;
      end
      if (issue_use_rs2 && (issue_rs2 != '0) && r_valid[i] && (r_rd[i] == issue_rs2)) begin
        w_hit2 = 1'b1;
        w_ld2  = r_load[i];
        w_idx2 = i;
      end
    end
  end

`ifdef HAZARD_FORWARD_EN
  // A load result only exists in the last stage; anything younger must wait
  assign w_haz1   = w_hit1 && w_ld1 && (w_idx1 != DEPTH - 1);
  assign w_haz2   = w_hit2 && w_ld2 && (w_idx2 != DEPTH - 1);
  // Select k forwards from stage k-1; 0 keeps the register-file value
  assign fwd_sel1 = (w_hit1 && !w_haz1) ? FWD_W'(w_idx1 + 1) : '0;
  assign fwd_sel2 = (w_hit2 && !w_haz2) ? FWD_W'(w_idx2 + 1) : '0;
`else
  // Without bypass paths every pending writer blocks its consumers
  assign w_haz1   = w_hit1;
  assign w_haz2   = w_hit2;
  assign fwd_sel1 = '0;
  assign fwd_sel2 = '0;
  logic w_unused_fwd;
  assign w_unused_fwd = ^{w_ld1, w_ld2, w_idx1, w_idx2};
`endif

  // Flush squashes the issue instruction, so it can neither stall nor enter the pipe
  assign w_stall  = issue_valid && !flush && (w_haz1 || w_haz2);
  assign w_accept = issue_valid && issue_regwrite && !w_stall && !flush && (issue_rd != '0);

  assign stall       = w_stall;
  assign stall_count = r_stall_count;

  // Shift the pipe every cycle; stage 0 takes the accepted issue or a bubble
  always_ff @(posedge clock) begin
    if (reset) begin
      r_valid <= '0;
      r_load  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_rd[i] <= '0;
      end
    end else begin
      r_valid[0] <= w_accept;
      r_load[0]  <= w_accept && issue_load;
      r_rd[0]    <= issue_rd;
      for (int i = 1; i < DEPTH; i++) begin
        r_valid[i] <= r_valid[i-1];
        r_load[i]  <= r_load[i-1];
        r_rd[i]    <= r_rd[i-1];
      end
    end
  end

  // Count stalled cycles, holding at the maximum instead of wrapping
  always_ff @(posedge clock) begin
    if (reset) begin
      r_stall_count <= '0;
    end else if (w_stall && (r_stall_count != C_COUNT_MAX)) begin
      r_stall_count <= r_stall_count + 16'd1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_hazard_scoreboard
// Description : Randomized and directed self-checking bench for
//               hazard_scoreboard (DEPTH=3), compared against an in-flight
//               list model that tracks producers by issue cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_scoreboard;

  localparam int REG_ADDR_W = 5;
  localparam int DEPTH      = 3;
  localparam int FWD_W      = $clog2(DEPTH + 1);

`ifdef HAZARD_FORWARD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic                  clock = 1'b0;
  logic                  reset;
  logic                  issue_valid;
  logic [REG_ADDR_W-1:0] issue_rd;
  logic                  issue_regwrite;
  logic                  issue_load;
  logic [REG_ADDR_W-1:0] issue_rs1;
  logic [REG_ADDR_W-1:0] issue_rs2;
  logic                  issue_use_rs1;
  logic                  issue_use_rs2;
  logic                  flush;
  logic                  stall;
  logic [FWD_W-1:0]      fwd_sel1;
  logic [FWD_W-1:0]      fwd_sel2;
  logic [15:0]           stall_count;

  always #5 clock = ~clock;

  hazard_scoreboard #(
    .REG_ADDR_W (REG_ADDR_W),
    .DEPTH      (DEPTH),
    .FWD_W      (FWD_W)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .issue_valid    (issue_valid),
    .issue_rd       (issue_rd),
    .issue_regwrite (issue_regwrite),
    .issue_load     (issue_load),
    .issue_rs1      (issue_rs1),
    .issue_rs2      (issue_rs2),
    .issue_use_rs1  (issue_use_rs1),
    .issue_use_rs2  (issue_use_rs2),
    .flush          (flush),
    .stall          (stall),
    .fwd_sel1       (fwd_sel1),
    .fwd_sel2       (fwd_sel2),
    .stall_count    (stall_count)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  // Reference model: list of accepted producers stamped with their issue cycle
  typedef struct {
    int rd;
    bit ld;
    int cyc;
  } ent_t;

  ent_t q[$];
  int   cyc    = 0;
  int   m_cnt  = 0;
  bit   chk_en = 1'b0;

  logic             obs_stall;
  logic [FWD_W-1:0] obs_sel1;
  logic [FWD_W-1:0] obs_sel2;

  // Youngest producer of rs decides: stage = cycles since issue minus one
  task automatic lookup(input logic [REG_ADDR_W-1:0] rs, input logic used,
                        output bit haz, output int sel);
    int stage;
    haz = 1'b0;
    sel = 0;
    if (used && rs != '0) begin
      for (int k = q.size() - 1; k >= 0; k--) begin
        if (q[k].rd == int'(rs)) begin
          stage = cyc - q[k].cyc - 1;
          if (!FWD) haz = 1'b1;
          else if (q[k].ld && stage < DEPTH - 1) haz = 1'b1;
          else sel = stage + 1;
          break;
        end
      end
    end
  endtask

  // One clock cycle: check outputs mid-cycle, then advance the model past the edge
  task automatic tick();
    bit h1, h2, m_stall, acc;
    int s1, s2;
    lookup(issue_rs1, issue_use_rs1, h1, s1);
    lookup(issue_rs2, issue_use_rs2, h2, s2);
    m_stall = issue_valid && !flush && (h1 || h2);
    acc = issue_valid && issue_regwrite && !m_stall && !flush && (issue_rd != '0);
    @(negedge clock);
    obs_stall = stall;
    obs_sel1  = fwd_sel1;
    obs_sel2  = fwd_sel2;
    if (chk_en) begin
      check("stall", 32'(stall), 32'(m_stall));
      check("stall_count", 32'(stall_count), 32'(m_cnt));
      if (!h1 && !h2) begin
        check("fwd_sel1", 32'(fwd_sel1), 32'(s1));
        check("fwd_sel2", 32'(fwd_sel2), 32'(s2));
      end
    end
    @(posedge clock);
    #1;
    if (reset) begin
      q.delete();
      m_cnt = 0;
    end else begin
      if (acc) q.push_back('{rd: int'(issue_rd), ld: issue_load, cyc: cyc});
      if (m_stall && m_cnt < 32'hFFFF) m_cnt++;
    end
    cyc++;
    while (q.size() > 0 && cyc - q[0].cyc - 1 >= DEPTH) void'(q.pop_front());
  endtask

  task automatic set_in(input logic v, input int rd, input logic rw, input logic ld,
                        input int r1, input int r2, input logic u1, input logic u2,
                        input logic fl);
    issue_valid    = v;
    issue_rd       = REG_ADDR_W'(rd);
    issue_regwrite = rw;
    issue_load     = ld;
    issue_rs1      = REG_ADDR_W'(r1);
    issue_rs2      = REG_ADDR_W'(r2);
    issue_use_rs1  = u1;
    issue_use_rs2  = u2;
    flush          = fl;
  endtask

  task automatic drain();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int k = 0; k < DEPTH + 1; k++) tick();
  endtask

  // Hold the current consumer until it issues; bounded so a stuck stall still ends
  task automatic run_consumer(output int nst, output int sel1, output int sel2);
    nst = 0;
    sel1 = 0;
    sel2 = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (!obs_stall) begin
        sel1 = int'(obs_sel1);
        sel2 = int'(obs_sel2);
        break;
      end
      nst++;
    end
  endtask

  initial begin
    int nst, s1, s2, c0;

    // Reset held two cycles with an instruction present
    reset = 1'b1;
    set_in(1, 3, 1, 0, 1, 2, 1, 1, 0);
    tick();
    chk_en = 1'b1;
    tick();
    check("rst_stall", 32'(obs_stall), 32'd0);
    check("rst_sel1", 32'(obs_sel1), 32'd0);
    check("rst_sel2", 32'(obs_sel2), 32'd0);
    check("rst_count", 32'(stall_count), 32'd0);
    reset = 1'b0;
    drain();

    // ALU producer followed directly by its consumer
    c0 = int'(stall_count);
    set_in(1, 1, 1, 0, 0, 0, 0, 0, 0);
    tick();
    set_in(1, 2, 1, 0, 1, 3, 1, 1, 0);
    run_consumer(nst, s1, s2);
    check("alu_stalls", 32'(nst), FWD ? 32'd0 : 32'd3);
    check("alu_sel1", 32'(s1), FWD ? 32'd1 : 32'd0);
    check("alu_count_delta", 32'(int'(stall_count) - c0), FWD ? 32'd0 : 32'd3);
    drain();

    // One independent instruction between producer and consumer
    set_in(1, 1, 1, 0, 0, 0, 0, 0, 0);
    tick();
    set_in(1, 4, 1, 0, 0, 0, 0, 0, 0);
    tick();
    set_in(1, 2, 1, 0, 1, 3, 1, 1, 0);
    run_consumer(nst, s1, s2);
    check("gap_stalls", 32'(nst), FWD ? 32'd0 : 32'd2);
    check("gap_sel1", 32'(s1), FWD ? 32'd2 : 32'd0);
    drain();

    // Load producer, consumer reading it on both operands
    set_in(1, 5, 1, 1, 0, 0, 0, 0, 0);
    tick();
    set_in(1, 6, 1, 0, 5, 5, 1, 1, 0);
    run_consumer(nst, s1, s2);
    check("load_stalls", 32'(nst), FWD ? 32'd2 : 32'd3);
    check("load_sel1", 32'(s1), FWD ? 32'd3 : 32'd0);
    check("load_sel2", 32'(s2), FWD ? 32'd3 : 32'd0);
    drain();

    // x0 is never a hazard; an unused rs2 never matches
    set_in(1, 0, 1, 0, 0, 0, 0, 0, 0);
    tick();
    set_in(1, 8, 1, 0, 0, 0, 1, 0, 0);
    tick();
    check("x0_stall", 32'(obs_stall), 32'd0);
    set_in(1, 7, 1, 0, 0, 0, 0, 0, 0);
    tick();
    set_in(1, 8, 1, 0, 2, 7, 1, 0, 0);
    tick();
    check("unused_rs2_stall", 32'(obs_stall), 32'd0);
    check("unused_rs2_sel2", 32'(obs_sel2), 32'd0);
    drain();

    // Flushed hazarding instruction: no stall, no count, and it never enters the pipe
    c0 = int'(stall_count);
    set_in(1, 9, 1, 0, 0, 0, 0, 0, 0);
    tick();
    set_in(1, 10, 1, 0, 9, 0, 1, 0, 1);
    tick();
    check("flush_stall", 32'(obs_stall), 32'd0);
    set_in(1, 11, 1, 0, 10, 0, 1, 0, 0);
    tick();
    check("flush_bubble", 32'(obs_stall), 32'd0);
    check("flush_count", 32'(int'(stall_count) - c0), 32'd0);
    drain();

    // Saturation: preload near the top, then stall past it
    force dut.r_stall_count = 16'hFFFE;
    #1;
    release dut.r_stall_count;
    m_cnt = 32'hFFFE;
    set_in(1, 1, 1, 1, 0, 0, 0, 0, 0);
    tick();
    set_in(1, 2, 1, 0, 1, 0, 1, 0, 0);
    run_consumer(nst, s1, s2);
    check("sat_count", 32'(stall_count), 32'hFFFF);
    drain();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("sat_reset", 32'(stall_count), 32'd0);

    // Randomized traffic over a small register set to provoke frequent matches
    for (int n = 0; n < 3000; n++) begin
      reset = ($urandom_range(0, 99) == 0);
      set_in($urandom_range(0, 3) != 0, int'($urandom_range(0, 7)),
             $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
             int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
             $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
             $urandom_range(0, 9) == 0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
